// File: rtl/mpsoc_wb_ext_guard.sv
// Wishbone B3 guard between a tile's external bus master and its local slave.
// In-window beats pass straight through. Out-of-window beats and beats that
// stall too long are terminated with err. Aborts are counted.
module mpsoc_wb_ext_guard #(
  parameter int unsigned    AW      = 32,
  parameter int unsigned    DW      = 32,
  parameter logic [AW-1:0]  BASE    = '0,
  parameter int unsigned    SIZE    = 1024,
  parameter int unsigned    TIMEOUT = 16,
  parameter int unsigned    CNT_W   = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  // master side
  input  logic [AW-1:0]      wbm_adr_i,
  input  logic [DW-1:0]      wbm_dat_i,
  input  logic [DW/8-1:0]    wbm_sel_i,
  input  logic               wbm_we_i,
  input  logic [1:0]         wbm_bte_i,
  input  logic [2:0]         wbm_cti_i,
  input  logic               wbm_cyc_i,
  input  logic               wbm_stb_i,
  output logic               wbm_ack_o,
  output logic               wbm_err_o,
  output logic               wbm_rty_o,
  output logic [DW-1:0]      wbm_dat_o,
  // slave side
  output logic [AW-1:0]      wbs_adr_o,
  output logic [DW-1:0]      wbs_dat_o,
  output logic [DW/8-1:0]    wbs_sel_o,
  output logic               wbs_we_o,
  output logic [1:0]         wbs_bte_o,
  output logic [2:0]         wbs_cti_o,
  output logic               wbs_cyc_o,
  output logic               wbs_stb_o,
  input  logic               wbs_ack_i,
  input  logic               wbs_err_i,
  input  logic [DW-1:0]      wbs_dat_i,
  // status
  output logic               timeout_o,
  output logic               decerr_o,
  output logic [CNT_W-1:0]   err_count_o
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             decerr_q, decerr_d;
  logic             abort_c;

  logic req_c;
  logic in_range_c;
  logic fwd_c;
  logic resp_c;

  // Per-beat request decode against the slave window
  always_comb begin
    req_c      = wbm_cyc_i & wbm_stb_i;
    in_range_c = (wbm_adr_i >= BASE) && ((wbm_adr_i - BASE) < AW'(SIZE));
    // Forwarding is also gated by reset so the slave sees nothing while held in reset
    fwd_c      = wb_rst_ni && (state_q != ST_ERR) && req_c && in_range_c;
    resp_c     = wbs_ack_i | wbs_err_i;
  end

  // Request pass-through and response return path, zero latency when forwarding
  always_comb begin
    wbs_adr_o = fwd_c ? wbm_adr_i : '0;
    wbs_dat_o = fwd_c ? wbm_dat_i : '0;
    wbs_sel_o = fwd_c ? wbm_sel_i : '0;
    wbs_we_o  = fwd_c & wbm_we_i;
    wbs_bte_o = fwd_c ? wbm_bte_i : 2'b00;
    wbs_cti_o = fwd_c ? wbm_cti_i : 3'b000;
    wbs_cyc_o = fwd_c;
    wbs_stb_o = fwd_c;
    wbm_ack_o = fwd_c & wbs_ack_i;
    wbm_err_o = (state_q == ST_ERR) | (fwd_c & wbs_err_i);
    wbm_dat_o = fwd_c ? wbs_dat_i : '0;
    wbm_rty_o = 1'b0;
  end

  // Next-state, beat timer and abort bookkeeping
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    decerr_d  = 1'b0;
    abort_c   = 1'b0;

    case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (!req_c) begin
          // master withdrew the beat: quiet return, nothing counted
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (!in_range_c) begin
          state_d  = ST_ERR;
          timer_d  = '0;
          decerr_d = 1'b1;
          abort_c  = 1'b1;
        end else if (resp_c) begin
          // a response on the last allowed cycle still wins over the abort
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d   = ST_ERR;
          timer_d   = '0;
          timeout_d = 1'b1;
          abort_c   = 1'b1;
        end else begin
          state_d = ST_WAIT;
          timer_d = timer_q + TW'(1);
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    if (abort_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, timer, abort flags and saturating abort counter
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      decerr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      decerr_q  <= decerr_d;
    end
  end

  // Status flags are high exactly during the single ERR cycle that follows an abort
  always_comb begin
    timeout_o   = timeout_q;
    decerr_o    = decerr_q;
    err_count_o = cnt_q;
  end

endmodule
